// File: rtl/pcie_irq_requester.sv
// pcie_irq_requester: turns per-channel interrupt edges into the PCIe DMA
// core's usr_irq_req/usr_irq_ack handshake. A request is held until it is
// acknowledged. Events seen while a channel is busy are folded into a single
// pending request, and every extra merged event is counted.
// Optional macro IRQ_ACK_TIMEOUT_EN: abandon a request after ACK_TIMEOUT
// cycles without an ack and raise a sticky irq_timeout flag.
module pcie_irq_requester #(
    parameter int IRQ_COUNT      = 4,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int ACK_TIMEOUT    = 1000000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [IRQ_COUNT-1:0] irq_in,
    input  logic [IRQ_COUNT-1:0] irq_enable,
    output logic [IRQ_COUNT-1:0] usr_irq_req,
    input  logic [IRQ_COUNT-1:0] usr_irq_ack,
    output logic [IRQ_COUNT-1:0] irq_pending,
    output logic [15:0]          coalesce_count,
    input  logic                 clear_stats,
    output logic [IRQ_COUNT-1:0] irq_timeout
);

    typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_t;

    // The holdoff counter only has to hold HOLDOFF_CYCLES-1
    localparam int HW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

    state_t               state    [IRQ_COUNT];
    logic [HW-1:0]        hold_cnt [IRQ_COUNT];
    logic [IRQ_COUNT-1:0] irq_prev;
    logic [IRQ_COUNT-1:0] irq_event;
    logic [IRQ_COUNT-1:0] coalesce_hit;
    logic [IRQ_COUNT-1:0] req_expired;

    function automatic logic [4:0] popcount(input logic [IRQ_COUNT-1:0] v);
        logic [4:0] pc;
        pc = '0;
        for (int i = 0; i < IRQ_COUNT; i++) pc = pc + 5'(v[i]);
        return pc;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign irq_event = irq_in & ~irq_prev & irq_enable;

    // An event coalesces when it lands on a busy channel that already has one pending
    always_comb begin
        coalesce_hit = '0;
        for (int i = 0; i < IRQ_COUNT; i++)
            coalesce_hit[i] = irq_event[i] & irq_pending[i] & (state[i] != IDLE);
    end

    // Edge-detect history, sampled every clock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) irq_prev <= '0;
        else         irq_prev <= irq_in;
    end

    // Per-channel request FSM: IDLE -> REQ -> (HOLDOFF) -> IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            usr_irq_req <= '0;
            irq_pending <= '0;
            for (int i = 0; i < IRQ_COUNT; i++) begin
                state[i]    <= IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IRQ_COUNT; i++) begin
                case (state[i])
                    IDLE: begin
                        irq_pending[i] <= 1'b0;
                        if (irq_event[i] | (irq_pending[i] & irq_enable[i])) begin
                            state[i]       <= REQ;
                            usr_irq_req[i] <= 1'b1;
                        end
                    end
                    REQ: begin
                        irq_pending[i] <= irq_enable[i] & (irq_pending[i] | irq_event[i]);
                        if (usr_irq_ack[i] | req_expired[i]) begin
                            usr_irq_req[i] <= 1'b0;
                            if (HOLDOFF_CYCLES == 0) begin
                                state[i] <= IDLE;
                            end else begin
                                state[i]    <= HOLDOFF;
                                hold_cnt[i] <= HOLD_LOAD;
                            end
                        end
                    end
                    HOLDOFF: begin
                        irq_pending[i] <= irq_enable[i] & (irq_pending[i] | irq_event[i]);
                        if (hold_cnt[i] == '0) state[i] <= IDLE;
                        else                   hold_cnt[i] <= hold_cnt[i] - HW'(1);
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    // Saturating count of merged events; clear wins over increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          coalesce_count <= '0;
        else if (clear_stats) coalesce_count <= '0;
        else                  coalesce_count <= sat_add(coalesce_count, popcount(coalesce_hit));
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);

    logic [31:0] to_cnt [IRQ_COUNT];

    always_comb begin
        req_expired = '0;
        for (int i = 0; i < IRQ_COUNT; i++)
            req_expired[i] = (state[i] == REQ) && (to_cnt[i] == TO_LAST);
    end

    // Ack-wait counter runs only while requesting; timeout flag is sticky
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_timeout <= '0;
            for (int i = 0; i < IRQ_COUNT; i++) to_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < IRQ_COUNT; i++) begin
                to_cnt[i] <= (state[i] == REQ) ? to_cnt[i] + 32'd1 : 32'd0;
                if (clear_stats)
                    irq_timeout[i] <= 1'b0;
                else if (req_expired[i] & ~usr_irq_ack[i])
                    irq_timeout[i] <= 1'b1;
            end
        end
    end
`else
    assign req_expired = '0;
    assign irq_timeout = '0;
`endif

endmodule

// File: doc/pcie_irq_requester.md
Name: pcie_irq_requester

Overview:
- Sits directly downstream of the millisecond timer's interrupt strobe and any other interrupt sources in the PCIe test design.
- Converts per-source interrupt edges into the PCIe DMA core's user-interrupt request/acknowledge handshake: usr_irq_req is held until usr_irq_ack is seen.
- Events arriving while a request is outstanding are coalesced into one pending request and counted.

Parameters:
- IRQ_COUNT, 4, number of interrupt channels (1..16).
- HOLDOFF_CYCLES, 8, idle gap enforced after each ack before the same channel may request again; 0 = no gap.
- ACK_TIMEOUT, 1000000, cycles to wait for ack before abandoning a request (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- irq_in  in  IRQ_COUNT  interrupt sources, level or strobe; rising edge is the event.
- irq_enable  in  IRQ_COUNT  per-channel enable.
- usr_irq_req  out  IRQ_COUNT  request to the PCIe core, one bit per channel.
- usr_irq_ack  in  IRQ_COUNT  single-cycle acknowledge from the PCIe core.
- irq_pending  out  IRQ_COUNT  channel holds an event not yet requested.
- coalesce_count  out  16  total events merged into an already-pending request; saturating.
- clear_stats  in  1  synchronous clear of coalesce_count and irq_timeout.
- irq_timeout  out  IRQ_COUNT  sticky ack-timeout flag (optional feature only).

Behaviour:
- Reset (async assert, sync-release assumed upstream): usr_irq_req=0, irq_pending=0, coalesce_count=0, irq_timeout=0, edge-detect history=0, all channels IDLE.
- Edge detect per channel: event = irq_in & ~irq_prev & irq_enable; irq_prev registered every clock.
- Per-channel FSM with states IDLE, REQ, HOLDOFF.
  - IDLE: if event or pending, go to REQ, set usr_irq_req=1 and clear pending. Latency: req is high on the clock after irq_in is first sampled high.
  - REQ: usr_irq_req held 1. On usr_irq_ack, drop req on the next clock and go to HOLDOFF (or to IDLE if HOLDOFF_CYCLES=0). Ack in IDLE/HOLDOFF is ignored.
  - HOLDOFF: down-counter loaded with HOLDOFF_CYCLES-1; go to IDLE when it reaches 0. Gap between req falling and next req rising = HOLDOFF_CYCLES+1 clocks minimum.
- Event in REQ or HOLDOFF: sets pending. If pending is already set, pending stays set and coalesce_count increments.
- Event in the same cycle as ack in REQ: event becomes pending; request is reissued after HOLDOFF.
- Counter arithmetic:
  - Multiple channels coalescing in the same cycle add their population count to coalesce_count.
  - Saturates at 16'hFFFF, no wrap.
  - clear_stats has priority over an increment in the same cycle.
- irq_enable low: new edges ignored and pending cleared. An outstanding REQ still completes its handshake.
- Channels are fully independent; no arbitration.

Optional Feature:
- Macro IRQ_ACK_TIMEOUT_EN.
- Defined: each channel has a 32-bit counter running in REQ. If it reaches ACK_TIMEOUT with no ack, req drops, irq_timeout[ch] sets (sticky until clear_stats or reset), and the channel goes to HOLDOFF. Pending is untouched.
- Undefined: REQ waits indefinitely; irq_timeout tied to 0; no counter logic.

Test Plan:
- Reset then irq_in[0] 0->1 at cycle 10 -> usr_irq_req[0]=1 from cycle 11. Ack at cycle 15 -> req=0 at 16; irq_pending=0; coalesce_count=0.
- Three rising edges on ch1 while REQ (ack withheld 50 cycles) -> irq_pending[1]=1, coalesce_count=2. After ack plus 9-clock gap, exactly one more req. Ack it -> req=0, pending=0.
- Event on ch2 coincident with ack, HOLDOFF_CYCLES=8 -> req falls, rises again exactly 9 clocks later.
- coalesce_count preset near saturation (65535 events) plus 2 more -> reads 16'hFFFF. clear_stats coincident with a coalesce -> reads 0.
- irq_enable[3]=0 with edges on ch3 -> no req, pending stays 0. Enable dropped while REQ -> handshake still completes on ack.
- IRQ_ACK_TIMEOUT_EN with ACK_TIMEOUT=20, no ack -> req drops after 20 cycles, irq_timeout[0]=1 held until clear_stats. Without the macro -> req stays high 1000 cycles.
